// File: rtl/mem_access_ctrl.sv
// Data RAM initiator for the MEM stage: one load/store at a time,
// big-endian byte lanes, one-cycle response pulse.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  state_t      state_nx;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [3:0]  cnt;
  logic        accept;
  logic        illegal;
  logic        last;
  logic        in_acc;
  logic [3:0]  sel;
  logic [31:0] lane_data;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;

  assign accept = req_valid && (state == IDLE);
  assign last   = (cnt == 4'd0);
  assign in_acc = (state == ACCESS);

  // Alignment and size legality of the incoming request
  always_comb begin
    illegal = 1'b0;
    unique case (req_size)
      2'b00:   illegal = 1'b0;
      2'b01:   illegal = req_addr[0];
      2'b10:   illegal = |req_addr[1:0];
      default: illegal = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = illegal ? RESP : ACCESS;
      ACCESS:  if (last) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request capture, wait countdown and load-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt     <= 4'd0;
    end else if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rdata_q <= 32'h0;
      err_q   <= illegal;
      cnt     <= 4'(WAIT_CYCLES);
    end else if (in_acc) begin
      if (last) rdata_q <= we_q ? 32'h0 : ld_ext;
      else      cnt <= cnt - 4'd1;
    end
  end

  // Big-endian lane enables and replicated store data
  always_comb begin
    sel       = 4'b1111;
    lane_data = wdata_q;
    unique case (size_q)
      2'b00: begin
        sel       = 4'b1000 >> addr_q[1:0];
        lane_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        sel       = addr_q[1] ? 4'b0011 : 4'b1100;
        lane_data = {2{wdata_q[15:0]}};
      end
      default: begin
        sel       = 4'b1111;
        lane_data = wdata_q;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    ld_b   = mem_data_i[31:24];
    ld_h   = addr_q[1] ? mem_data_i[15:0] : mem_data_i[31:16];
    ld_ext = mem_data_i;
    unique case (addr_q[1:0])
      2'b00:   ld_b = mem_data_i[31:24];
      2'b01:   ld_b = mem_data_i[23:16];
      2'b10:   ld_b = mem_data_i[15:8];
      default: ld_b = mem_data_i[7:0];
    endcase
    unique case (size_q)
      2'b00:   ld_ext = {{24{~uns_q & ld_b[7]}}, ld_b};
      2'b01:   ld_ext = {{16{~uns_q & ld_h[15]}}, ld_h};
      default: ld_ext = mem_data_i;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_err   = resp_valid & err_q;
  assign mem_ce     = in_acc;
  assign mem_we     = in_acc & we_q;
  assign mem_addr   = in_acc ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_sel    = in_acc ? sel : 4'b0000;
  assign mem_data_o = in_acc ? lane_data : 32'h0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-array reference model, RAM model,
// directed literal checks, random traffic and a WAIT_CYCLES=3 instance.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;

  logic        v3;
  logic        ready3;
  logic        rv3;
  logic        re3;
  logic        ce3;
  logic        we3;
  logic [31:0] rd3;
  logic [31:0] ma3;
  logic [31:0] mo3;
  logic [3:0]  s3;

  always #5 clk = ~clk;

  mem_access_ctrl #(.WAIT_CYCLES(0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_sel(mem_sel), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i)
  );

  mem_access_ctrl #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(v3), .req_ready(ready3),
    .req_we(1'b0), .req_size(2'b10),
    .req_unsigned(1'b0), .req_addr(32'h40),
    .req_wdata(32'h0),
    .resp_valid(rv3), .resp_rdata(rd3), .resp_err(re3),
    .mem_ce(ce3), .mem_we(we3), .mem_addr(ma3),
    .mem_sel(s3), .mem_data_o(mo3),
    .mem_data_i(32'hCAFEF00D)
  );

  // RAM model: 64 words, combinational read, lane-enabled write
  logic [31:0] ram [0:63];
  assign mem_data_i = ram[mem_addr[7:2]];
  always @(posedge clk)
    if (mem_ce && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_sel[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_data_o[8*b +: 8];

  typedef struct {
    int          acc;
    bit          err;
    bit          we;
    int          n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  sel;
    logic [31:0] mdata;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  gm [0:255];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          run = 0;
  bit          ph3 = 0;
  logic [31:0] last_rdata;
  logic        last_err;
  logic [3:0]  last_sel;
  logic [31:0] last_mdata;
  int          n_acc3 = 0;
  int          n_resp3 = 0;
  int          last_rv3 = -1;
  int          cerun = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected outcome of one request, from byte-array semantics
  function automatic exp_t model(input logic we, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] a,
                                 input logic [31:0] wd, input int c);
    exp_t e;
    int n;
    int off;
    int p;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = int'(a[1:0]);
    e.acc = c; e.we = we; e.n = n; e.addr = a; e.wdata = wd;
    e.sel = 4'h0; e.mdata = 32'h0; e.rdata = 32'h0;
    e.err = (sz == 2'd3) || (off % n != 0);
    if (!e.err) begin
      for (int i = 0; i < n; i++) e.sel[3 - (off + i)] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        p = 3 - k;
        e.mdata[8*k +: 8] = wd[8*((n - 1) - (p % n)) +: 8];
      end
      if (!we) begin
        v = 32'h0;
        for (int i = 0; i < n; i++)
          v = (v << 8) | 32'(gm[(int'(a[7:0]) + i) & 255]);
        if (!uns && n < 4 && v[8*n - 1])
          v = v | ~((32'h1 << (8*n)) - 32'h1);
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // Acceptance tracking; reset drops anything outstanding
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) q.delete();
    else if (req_valid && req_ready)
      q.push_back(model(req_we, req_size, req_unsigned, req_addr, req_wdata, cyc));
    if (!rst && v3 && ready3) n_acc3++;
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (run && !rst) begin
      chk("ready", req_ready, q.size() == 0);
      if (q.size() != 0 && !q[0].err && cyc == q[0].acc) begin
        chk("ce", mem_ce, 1);
        chk("mem_we", mem_we, q[0].we);
        chk("mem_addr", mem_addr, {q[0].addr[31:2], 2'b00});
        chk("mem_sel", mem_sel, q[0].sel);
        chk("mem_data_o", mem_data_o, q[0].mdata);
        last_sel = mem_sel;
        last_mdata = mem_data_o;
      end else begin
        chk("mem_idle", mem_ce | mem_we | (|mem_sel) | (|mem_addr) | (|mem_data_o), 0);
      end
      if (resp_valid) begin
        if (q.size() == 0) begin
          chk("resp_unexpected", resp_valid, 0);
        end else begin
          chk("resp_cycle", cyc, q[0].acc + (q[0].err ? 0 : 1));
          chk("resp_rdata", resp_rdata, q[0].rdata);
          chk("resp_err", resp_err, q[0].err);
          last_rdata = resp_rdata;
          last_err = resp_err;
          if (!q[0].err && q[0].we)
            for (int i = 0; i < q[0].n; i++)
              gm[(int'(q[0].addr[7:0]) + i) & 255] = q[0].wdata[8*(q[0].n - 1 - i) +: 8];
          void'(q.pop_front());
        end
      end else begin
        chk("resp_quiet", resp_err | (|resp_rdata), 0);
      end
    end
    if (ph3 && !rst) begin
      chk("ready3", ready3, !(ce3 || rv3));
      if (ce3) begin
        cerun++;
        chk("ce3_bus", (ma3 == 32'h40) && (s3 == 4'hF) && (mo3 == 32'h0) && !we3, 1);
      end else if (cerun != 0) begin
        chk("ce3_len", cerun, 4);
        cerun = 0;
      end
      if (rv3) begin
        chk("rd3", rd3, 32'hCAFEF00D);
        chk("re3", re3, 0);
        if (last_rv3 >= 0) chk("rv3_gap", cyc - last_rv3, 6);
        last_rv3 = cyc;
        n_resp3++;
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input bit junk);
    int k;
    req_valid = 1'b1; req_we = we; req_size = sz;
    req_unsigned = uns; req_addr = a; req_wdata = wd;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    if (junk) begin
      req_we = 1'($urandom); req_size = 2'($urandom);
      req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    end else begin
      req_valid = 1'b0;
    end
    k = 0;
    do begin @(negedge clk); #1; k++; end while (q.size() != 0 && k < 40);
    chk("complete", q.size() == 0, 1);
    req_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    for (int i = 0; i < 256; i++) gm[i] = 8'h0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; v3 = 1'b0;
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_resp", resp_valid | resp_err | (|resp_rdata), 0);
    chk("rst_mem", mem_ce | mem_we | (|mem_sel) | (|mem_addr) | (|mem_data_o), 0);
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0; run = 1'b1;

    // Store interrupted by reset while in ACCESS
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1; #1;
    chk("rst_drop_ce", mem_ce, 0);
    chk("rst_drop_we", mem_we, 0);
    @(negedge clk); @(negedge clk); #1; rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    issue(0, 2'b10, 0, 32'h10, 0, 0);
    chk("lw_after_rst", last_rdata, 32'h0);

    issue(1, 2'b10, 0, 32'h20, 32'h11223344, 1);
    chk("sw_sel", last_sel, 4'hF);
    chk("sw_data", last_mdata, 32'h11223344);
    issue(0, 2'b00, 0, 32'h21, 0, 0); chk("lb_21", last_rdata, 32'h22);
    issue(0, 2'b00, 1, 32'h23, 0, 0); chk("lbu_23", last_rdata, 32'h44);
    issue(0, 2'b01, 0, 32'h22, 0, 0); chk("lh_22", last_rdata, 32'h3344);

    issue(1, 2'b00, 0, 32'h31, 32'h80, 0);
    chk("sb_sel", last_sel, 4'b0100);
    chk("sb_data", last_mdata, 32'h80808080);
    issue(0, 2'b00, 0, 32'h31, 0, 0); chk("lb_31", last_rdata, 32'hFFFFFF80);
    issue(0, 2'b00, 1, 32'h31, 0, 1); chk("lbu_31", last_rdata, 32'h80);
    issue(0, 2'b10, 0, 32'h30, 0, 0); chk("lw_30", last_rdata, 32'h00800000);

    issue(1, 2'b01, 0, 32'h42, 32'hBEEF, 0);
    chk("sh_sel", last_sel, 4'b0011);
    chk("sh_data", last_mdata, 32'hBEEFBEEF);
    issue(0, 2'b01, 0, 32'h42, 0, 0); chk("lh_42", last_rdata, 32'hFFFFBEEF);
    issue(0, 2'b01, 1, 32'h42, 0, 0); chk("lhu_42", last_rdata, 32'h0000BEEF);

    issue(0, 2'b10, 0, 32'h45, 0, 1);
    chk("lw45_err", last_err, 1); chk("lw45_rd", last_rdata, 0);
    issue(0, 2'b01, 0, 32'h47, 0, 0);
    chk("lh47_err", last_err, 1); chk("lh47_rd", last_rdata, 0);
    issue(1, 2'b11, 0, 32'h48, 32'h5555AAAA, 0);
    chk("sz3_err", last_err, 1); chk("sz3_rd", last_rdata, 0);

    for (int t = 0; t < 200; t++) begin
      issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
            32'($urandom_range(0, 63)), $urandom, 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      #1;
    end

    ph3 = 1'b1;
    @(posedge clk); #1;
    v3 = 1'b1;
    repeat (62) @(posedge clk);
    #1; v3 = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("w3_accepts", n_acc3, 11);
    chk("w3_resps", n_resp3, 11);

    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator-side controller for the byte-lane data RAM port used by the MEM stage. It accepts one load/store request at a time from the pipeline over a valid/ready handshake and drives the RAM's chip-enable, write-enable, address, byte-select and write-data signals. It captures the combinational read data, then returns either a sign/zero-extended load result or a store completion as a one-cycle response. Byte order is big-endian, so byte offset 0 maps to bits [31:24].

Parameters:
WAIT_CYCLES, 0, extra cycles the RAM access is held before read data is sampled or the access retires (0..15).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  controller can accept a request (IDLE only)
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned or illegal-size request, qualified by resp_valid
mem_ce  out  1  RAM chip enable
mem_we  out  1  RAM write enable
mem_addr  out  32  word-aligned address, {req_addr[31:2], 2'b00}
mem_sel  out  4  byte lane enables, bit 3 = bits [31:24]
mem_data_o  out  32  lane-replicated store data
mem_data_i  in  32  RAM read data (combinational)

Behaviour:
- Reset (asynchronous): state IDLE. All outputs are 0 except req_ready = 1. Wait counter is 0.
- Handshake: a request is accepted on a rising edge with req_valid && req_ready. All request fields are registered at acceptance. req_ready = 1 only in IDLE.
- State IDLE:
  - On acceptance of a legal request, go to ACCESS.
  - On acceptance of an illegal request, go to RESP with the error flag set. Illegal means: size 11; half with addr[0] = 1; word with addr[1:0] != 0.
- State ACCESS:
  - mem_ce = 1; mem_we = registered we; mem_addr, mem_sel and mem_data_o are driven from the registered request.
  - The wait counter loads WAIT_CYCLES on entry and decrements each cycle. When it reaches 0, go to RESP.
  - For a load, mem_data_i is captured on that final edge.
  - For a store, the RAM commits on every ACCESS edge with identical data, which is idempotent.
- State RESP: resp_valid = 1 for exactly one cycle, then return to IDLE. There is no back-pressure on responses.
- Timing with WAIT_CYCLES = 0 and the request accepted at edge E:
  - ACCESS spans the cycle after E.
  - resp_valid is high in the cycle after E+1.
  - Illegal request: resp_valid is high in the cycle after E.
  - Throughput: one request per 3 + WAIT_CYCLES cycles (2 cycles for errors).
- Outside ACCESS: mem_ce, mem_we, mem_sel, mem_addr and mem_data_o are all 0.
- Lane select (big-endian):
  - Byte: offset 0→1000, 1→0100, 2→0010, 3→0001.
  - Half: offset 0→1100, offset 2→0011.
  - Word: 1111.
- Store data: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- Load extraction:
  - Byte: lane chosen by offset (0 → [31:24]), extended to 32 bits.
  - Half: offset 0 → [31:16], offset 2 → [15:0], extended.
  - Word: passed through unchanged; req_unsigned is ignored.
- resp_rdata and resp_err are valid only while resp_valid = 1 and are 0 otherwise. resp_rdata = 0 on stores and on errors.
- resp_err = 1 forces no RAM activity: mem_ce is never asserted for that request.
- Reset mid-operation:
  - rst asserted during ACCESS deasserts mem_ce/mem_we immediately (asynchronously), so no write commits on the following edge.
  - Any pending response is dropped.
- req_valid while busy is ignored. Its fields may change freely and are not sampled.

Test Plan:
- Reset asserted mid-ACCESS of a store of 0xDEADBEEF to 0x10 → mem_ce/mem_we drop at once; no resp_valid; a later LW 0x10 does not return 0xDEADBEEF (RAM preloaded with 0).
- SW 0x11223344 @0x20, then LB 0x21 signed / LBU 0x23 / LH 0x22 signed → 0x00000022, 0x00000044, 0x00003344; stores drive sel 1111, data 0x11223344; WAIT_CYCLES=0 gives resp_valid 2 cycles after acceptance.
- SB 0x80 @0x31 over a word 0 → sel 0100, mem_data_o 0x80808080; LB 0x31 → 0xFFFFFF80; LBU 0x31 → 0x00000080; LW 0x30 → 0x00800000.
- SH 0xBEEF @0x42 → sel 0011, data 0xBEEFBEEF; LH 0x42 → 0xFFFFBEEF; LHU → 0x0000BEEF.
- Misaligned LW @0x45, LH @0x47, size 11 @0x48 → resp_err=1, resp_rdata=0, resp_valid 1 cycle after acceptance, mem_ce never asserted.
- WAIT_CYCLES=3, back-to-back req_valid held high → req_ready high only in IDLE, one response every 6 cycles, mem_ce high 4 cycles per access, no request lost or duplicated.
